alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 115 +++++++++++
 tb/tb_alu_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between two requesters.
// Latency: request seen at edge k -> gnt in cycle k+1 -> done in cycle k+2; one op per 3 cycles.
// Backpressure: a requester holds req until its done; requests seen outside IDLE wait for IDLE.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [2:0]  op0,
  input  logic [2:0]  op1,
  input  logic [15:0] a0,
  input  logic [15:0] a1,
  input  logic [15:0] b0,
  input  logic [15:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] result,
  output logic        zero,
  output logic        div_err,
  output logic        busy,
  output logic [2:0]  alu_aluop,
  output logic [15:0] alu_input1,
  output logic [15:0] alu_reg_out,
  output logic        alu_alusrc,
  output logic [15:0] alu_immd,
  input  logic [15:0] alu_out,
  input  logic        alu_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_DIV = 3'd7;

  state_t      state;
  logic [2:0]  op_r;
  logic [15:0] a_r;
  logic [15:0] b_r;
  logic        owner;
  logic        last;
  logic        win;

  // On a tie the requester not granted last time wins.
  assign win = (req0 & req1) ? ~last : req1;

  assign busy        = (state != IDLE);
  assign alu_aluop   = op_r;
  assign alu_input1  = a_r;
  assign alu_reg_out = b_r;
  assign alu_alusrc  = 1'b0;
  assign alu_immd    = 16'h0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_r    <= 3'd0;
      a_r     <= 16'h0000;
      b_r     <= 16'h0000;
      owner   <= 1'b0;
      last    <= 1'b1;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      div_err <= 1'b0;
      result  <= 16'h0000;
      zero    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            op_r  <= win ? op1 : op0;
            a_r   <= win ? a1 : a0;
            b_r   <= win ? b1 : b0;
            owner <= win;
            last  <= win;
            gnt0  <= ~win;
            gnt1  <= win;
            state <= EXEC;
          end
        end
        EXEC: begin
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          done0 <= ~owner;
          done1 <= owner;
          state <= DONE;
          if (op_r == OP_NOP) begin
            result  <= 16'h0000;
            zero    <= 1'b1;
            div_err <= 1'b0;
          end else if (op_r == OP_DIV && b_r == 16'h0000) begin
            result  <= 16'hFFFF;
            zero    <= 1'b0;
            div_err <= 1'b1;
          end else begin
            result  <= alu_out;
            zero    <= alu_zero;
            div_err <= 1'b0;
          end
        end
        DONE: begin
          done0   <= 1'b0;
          done1   <= 1'b0;
          div_err <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a cycle-level transaction model,
// with a behavioural ALU answering the arbiter's ALU port.
module tb_alu_arbiter;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rq [2];
  logic [2:0]  rop [2];
  logic [15:0] ra [2];
  logic [15:0] rb [2];
  logic        req0, req1;
  logic [2:0]  op0, op1;
  logic [15:0] a0, a1, b0, b1;
  logic        gnt0, gnt1, done0, done1, zero, div_err, busy, alu_alusrc, alu_zero;
  logic [15:0] result, alu_input1, alu_reg_out, alu_immd, alu_out;
  logic [2:0]  alu_aluop;

  always #5 clk = ~clk;

  assign req0 = rq[0];
  assign req1 = rq[1];
  assign op0  = rop[0];
  assign op1  = rop[1];
  assign a0   = ra[0];
  assign a1   = ra[1];
  assign b0   = rb[0];
  assign b1   = rb[1];

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1), .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1), .result(result), .zero(zero), .div_err(div_err),
    .busy(busy), .alu_aluop(alu_aluop), .alu_input1(alu_input1), .alu_reg_out(alu_reg_out),
    .alu_alusrc(alu_alusrc), .alu_immd(alu_immd), .alu_out(alu_out), .alu_zero(alu_zero)
  );

  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = {16'h0000, a} * {16'h0000, b};
    case (op)
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return a ^ b;
      3'd4: return a + b;
      3'd5: return a - b;
      3'd6: return p[15:0];
      3'd7: return (b == 16'h0000) ? 16'h0000 : a / b;
      default: return 16'h0000;
    endcase
  endfunction

  // Behavioural ALU; NOP and divide-by-zero answers are deliberately bogus so overrides are visible.
  always_comb begin
    alu_out  = alu_fn(alu_aluop, alu_input1, alu_reg_out);
    alu_zero = (alu_fn(alu_aluop, alu_input1, alu_reg_out) == 16'h0000);
    if (alu_aluop == 3'd0) begin
      alu_out  = 16'hDEAD;
      alu_zero = 1'b0;
    end else if (alu_aluop == 3'd7 && alu_reg_out == 16'h0000) begin
      alu_out  = 16'h1234;
      alu_zero = 1'b1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction model: phase 0 idle, 1 operands held by the ALU, 2 result presented.
  int          ph, mown, mlast;
  logic [2:0]  mop;
  logic [15:0] ma, mb, mres;
  logic        mzero, mdiv;
  txn_t        q0[$], q1[$];
  int          gnt_log[$];
  int          div_seen;
  bit          rnd_en;

  task automatic model_reset();
    ph = 0; mown = 0; mlast = 1; mop = 3'd0; ma = 16'h0; mb = 16'h0;
    mres = 16'h0; mzero = 1'b0; mdiv = 1'b0;
  endtask

  task automatic model_update();
    int w;
    if (ph == 0) begin
      if (rq[0] || rq[1]) begin
        if (rq[0] && rq[1]) w = (mlast == 1) ? 0 : 1;
        else                w = rq[0] ? 0 : 1;
        mop = rop[w]; ma = ra[w]; mb = rb[w]; mown = w; mlast = w; ph = 1;
      end
    end else if (ph == 1) begin
      mdiv = 1'b0;
      if (mop == 3'd0) begin
        mres = 16'h0000; mzero = 1'b1;
      end else if (mop == 3'd7 && mb == 16'h0000) begin
        mres = 16'hFFFF; mzero = 1'b0; mdiv = 1'b1;
      end else begin
        case (mop)
          3'd1: mres = ma & mb;
          3'd2: mres = ma | mb;
          3'd3: mres = ma ^ mb;
          3'd4: mres = 16'((32'(ma) + 32'(mb)) % 65536);
          3'd5: mres = 16'((32'(ma) + 65536 - 32'(mb)) % 65536);
          3'd6: mres = 16'((32'(ma) * 32'(mb)) % 65536);
          default: mres = 16'(32'(ma) / 32'(mb));
        endcase
        mzero = (mres == 16'h0000);
      end
      ph = 2;
    end else begin
      ph = 0; mdiv = 1'b0;
    end
  endtask

  task automatic check_outputs();
    chk("gnt0", gnt0, (ph == 1 && mown == 0));
    chk("gnt1", gnt1, (ph == 1 && mown == 1));
    chk("done0", done0, (ph == 2 && mown == 0));
    chk("done1", done1, (ph == 2 && mown == 1));
    chk("busy", busy, (ph != 0));
    chk("div_err", div_err, (ph == 2) && mdiv);
    chk("result", result, mres);
    chk("zero", zero, mzero);
    chk("alusrc_immd", {alu_alusrc, alu_immd}, 0);
    if (ph == 1) chk("alu_ops", {alu_aluop, alu_input1, alu_reg_out}, {mop, ma, mb});
  endtask

  task automatic rand_txn(output txn_t t);
    t.op = 3'($urandom_range(7));
    t.a  = 16'($urandom);
    t.b  = ($urandom_range(3) == 0) ? 16'h0000 : 16'($urandom_range(65535) >> $urandom_range(15));
  endtask

  task automatic step();
    txn_t t;
    @(negedge clk);
    check_outputs();
    if (gnt0) gnt_log.push_back(0);
    if (gnt1) gnt_log.push_back(1);
    if (div_err) div_seen++;
    for (int n = 0; n < 2; n++) begin
      if (ph == 2 && mown == n) begin
        rq[n] = 1'b0;
      end else if (ph == 1 && mown == n) begin
        rop[n] = 3'($urandom_range(7)); ra[n] = 16'($urandom); rb[n] = 16'($urandom);
      end else if (!rq[n]) begin
        if (rnd_en && $urandom_range(2) == 0) begin
          rand_txn(t);
          if (n == 0) q0.push_back(t); else q1.push_back(t);
        end
        if (n == 0 && q0.size() > 0) begin
          t = q0.pop_front(); rq[0] = 1'b1; rop[0] = t.op; ra[0] = t.a; rb[0] = t.b;
        end else if (n == 1 && q1.size() > 0) begin
          t = q1.pop_front(); rq[1] = 1'b1; rop[1] = t.op; ra[1] = t.a; rb[1] = t.b;
        end
      end
    end
    @(posedge clk);
    model_update();
  endtask

  task automatic run_until_idle(input int max);
    int c;
    c = 0;
    do begin
      step();
      c++;
    end while ((q0.size() > 0 || q1.size() > 0 || rq[0] || rq[1] || ph != 0) && c < max);
    chk("drain_in_budget", (c < max), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rq[0] = 1'b0; rq[1] = 1'b0;
    q0.delete(); q1.delete();
    model_reset();
    @(negedge clk);
    chk("rst_outputs", {gnt0, gnt1, done0, done1, div_err, busy, zero, result}, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    txn_t t;
    int c;
    for (int n = 0; n < 2; n++) begin
      rq[n] = 1'b0; rop[n] = 3'd0; ra[n] = 16'h0; rb[n] = 16'h0;
    end
    rnd_en = 1'b0;
    div_seen = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("por_outputs", {gnt0, gnt1, done0, done1, div_err, busy, zero, result}, 0);
    chk("por_alu_ops", {alu_aluop, alu_input1, alu_reg_out}, 0);
    rst_n = 1'b1;
    step();

    // Single ADD from requester 0.
    gnt_log.delete();
    t = '{op: 3'd4, a: 16'h0005, b: 16'h0003}; q0.push_back(t);
    run_until_idle(20);
    chk("add_result", {zero, result}, {1'b0, 16'h0008});
    chk("add_gnt_count", gnt_log.size(), 1);
    if (gnt_log.size() == 1) chk("add_gnt_who", gnt_log[0], 0);

    // Simultaneous requests straight after reset: requester 0 first.
    do_reset();
    gnt_log.delete();
    t = '{op: 3'd5, a: 16'h0007, b: 16'h0007}; q0.push_back(t);
    t = '{op: 3'd1, a: 16'hF0F0, b: 16'h0F0F}; q1.push_back(t);
    run_until_idle(30);
    chk("tie_result", {zero, result}, {1'b1, 16'h0000});
    chk("tie_gnt_count", gnt_log.size(), 2);
    if (gnt_log.size() == 2) chk("tie_gnt_order", {gnt_log[0][0], gnt_log[1][0]}, 2'b01);

    // Both held for four operations: strict alternation.
    gnt_log.delete();
    for (int i = 0; i < 2; i++) begin
      t = '{op: 3'd2, a: 16'(i), b: 16'h0100}; q0.push_back(t);
      t = '{op: 3'd3, a: 16'h00FF, b: 16'(i)}; q1.push_back(t);
    end
    run_until_idle(40);
    chk("alt_gnt_count", gnt_log.size(), 4);
    if (gnt_log.size() == 4)
      chk("alt_gnt_order", {gnt_log[0][0], gnt_log[1][0], gnt_log[2][0], gnt_log[3][0]}, 4'b0101);

    // Divide by zero, then a MUL that wraps to zero.
    div_seen = 0;
    t = '{op: 3'd7, a: 16'h0010, b: 16'h0000}; q1.push_back(t);
    run_until_idle(20);
    chk("div0_result", {zero, result}, {1'b0, 16'hFFFF});
    chk("div0_err_pulses", div_seen, 1);
    t = '{op: 3'd6, a: 16'h0100, b: 16'h0100}; q1.push_back(t);
    run_until_idle(20);
    chk("mul_wrap_result", {zero, result}, {1'b1, 16'h0000});

    // Reset during EXEC abandons the operation and restores requester 0 priority.
    t = '{op: 3'd4, a: 16'h0001, b: 16'h0001}; q1.push_back(t);
    c = 0;
    while (ph != 1 && c < 10) begin
      step();
      c++;
    end
    chk("reach_exec", (c < 10), 1);
    #2 rst_n = 1'b0;
    rq[0] = 1'b0; rq[1] = 1'b0;
    q0.delete(); q1.delete();
    model_reset();
    #1;
    chk("async_rst_outputs", {gnt0, gnt1, done0, done1, div_err, busy, zero, result}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    gnt_log.delete();
    t = '{op: 3'd3, a: 16'h1234, b: 16'h1234}; q0.push_back(t);
    t = '{op: 3'd2, a: 16'h1200, b: 16'h0034}; q1.push_back(t);
    run_until_idle(30);
    chk("post_rst_gnt_count", gnt_log.size(), 2);
    if (gnt_log.size() == 2) chk("post_rst_gnt_order", {gnt_log[0][0], gnt_log[1][0]}, 2'b01);
    chk("post_rst_result", {zero, result}, {1'b0, 16'h1234});

    // Random traffic.
    rnd_en = 1'b1;
    repeat (600) step();
    rnd_en = 1'b0;
    run_until_idle(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
